// File: rtl/mips_uart_tx_port_if.sv
// Purpose : processor data-memory bus as seen by the memory-mapped UART transmit port.
// Latency : wires only; ReadData is produced combinationally by the slave.
// Backpressure: none on the bus; the slave drops stores it cannot accept and flags them.
//
// Signals:
//   Address   [31:0]  byte address of the MEM-stage access (master -> slave)
//   WriteData [31:0]  store data (master -> slave)
//   MemWrite          store strobe, sampled on the rising clock edge (master -> slave)
//   MemRead           load qualifier, combinational (master -> slave)
//   ReadData  [31:0]  load data back to the processor load mux (slave -> master)
interface mips_uart_tx_port_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;

    modport master (
        output Address,
        output WriteData,
        output MemWrite,
        output MemRead,
        input  ReadData
    );

    modport slave (
        input  Address,
        input  WriteData,
        input  MemWrite,
        input  MemRead,
        output ReadData
    );
endinterface

// File: rtl/mips_uart_tx_port.sv
// Purpose : memory-mapped UART transmitter (8N1, LSB first) fed by a 4-entry byte FIFO.
// Latency : a store to TX_ADDR into an empty, idle port starts the start bit one edge later.
// Backpressure: stores to a full FIFO are dropped and latch the sticky Overflow status bit.
//
// Ports:
//   clk       single clock, all state on the rising edge
//   reset     asynchronous, active-low; aborts any frame and empties the FIFO
//   bus       processor bus (slave modport): Address, WriteData, MemWrite, MemRead, ReadData
//   TxSerial  registered UART line, idles high
//   TxBusy    high while a frame is in flight or bytes are queued
//
// Register map:
//   TX_ADDR      write: WriteData[7:0] queued for transmission
//   STATUS_ADDR  read : {28'b0, Overflow, Full, Empty, TxBusy}
//                write: WriteData[0]=1 clears Overflow
module mips_uart_tx_port #(
    parameter int unsigned CLK_PER_BIT = 434,
    parameter logic [31:0] TX_ADDR     = 32'h1001_0024,
    parameter logic [31:0] STATUS_ADDR = 32'h1001_0028
) (
    input  logic                      clk,
    input  logic                      reset,
    mips_uart_tx_port_if.slave        bus,
    output logic                      TxSerial,
    output logic                      TxBusy
);

    // Baud counter is sized for the widest legal CLK_PER_BIT (65535).
    localparam logic [15:0] BAUD_LAST = 16'(CLK_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_t;

    txState_t    state;
    logic [15:0] baudCnt;
    logic [2:0]  bitIdx;
    logic [7:0]  shiftReg;

    logic [7:0]  fifoMem [4];
    logic [1:0]  wrPtr;
    logic [1:0]  rdPtr;
    logic [2:0]  count;
    logic        overflow;

    logic        full;
    logic        empty;
    logic        txWrite;
    logic        statusWrite;
    logic        statusRead;
    logic        pop;
    logic        pushOk;
    logic        baudDone;

    // Only the low byte (TX) and bit 0 (STATUS) of store data carry meaning.
    logic        unusedWriteData;
    assign unusedWriteData = ^bus.WriteData[31:8];

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign txWrite     = bus.MemWrite && (bus.Address == TX_ADDR);
    assign statusWrite = bus.MemWrite && (bus.Address == STATUS_ADDR);
    assign statusRead  = bus.MemRead  && (bus.Address == STATUS_ADDR);

    assign full  = (count == 3'd4);
    assign empty = (count == 3'd0);

    // The FSM drains the FIFO head whenever it sits in IDLE with data queued.
    assign pop = (state == IDLE) && !empty;

    // A pop on the same edge frees a slot, so a push into a full FIFO is
    // still accepted when the transmitter takes the head byte that cycle.
    assign pushOk = txWrite && (!full || pop);

    assign TxBusy = (state != IDLE) || !empty;

    assign bus.ReadData = statusRead ? {28'b0, overflow, full, empty, TxBusy} : 32'h0;

    // ------------------------------------------------------------------
    // FIFO storage: data array needs no reset, occupancy is tracked below.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (pushOk) begin
            fifoMem[wrPtr] <= bus.WriteData[7:0];
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers, occupancy and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr    <= 2'd0;
            rdPtr    <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + 2'd1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 2'd1;
            end

            case ({pushOk, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase

            // TX and STATUS decodes are mutually exclusive, so the order of
            // these two branches never matters in practice.
            if (txWrite && !pushOk) begin
                overflow <= 1'b1;
            end else if (statusWrite && bus.WriteData[0]) begin
                overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM; TxSerial is registered so the line never glitches.
    // Each state holds the line for exactly CLK_PER_BIT cycles; the line
    // value for the next state is loaded on the edge that enters it.
    // ------------------------------------------------------------------
    assign baudDone = (baudCnt == BAUD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            TxSerial <= 1'b1;
            baudCnt  <= 16'd0;
            bitIdx   <= 3'd0;
            shiftReg <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    TxSerial <= 1'b1;
                    baudCnt  <= 16'd0;
                    bitIdx   <= 3'd0;
                    if (pop) begin
                        shiftReg <= fifoMem[rdPtr];
                        TxSerial <= 1'b0;
                        state    <= START;
                    end
                end

                START: begin
                    if (baudDone) begin
                        baudCnt  <= 16'd0;
                        bitIdx   <= 3'd0;
                        TxSerial <= shiftReg[0];
                        state    <= DATA;
                    end else begin
                        baudCnt <= baudCnt + 16'd1;
                    end
                end

                DATA: begin
                    if (baudDone) begin
                        baudCnt <= 16'd0;
                        if (bitIdx == 3'd7) begin
                            TxSerial <= 1'b1;
                            state    <= STOP;
                        end else begin
                            bitIdx   <= bitIdx + 3'd1;
                            TxSerial <= shiftReg[bitIdx + 3'd1];
                        end
                    end else begin
                        baudCnt <= baudCnt + 16'd1;
                    end
                end

                STOP: begin
                    if (baudDone) begin
                        baudCnt <= 16'd0;
                        state   <= IDLE;
                    end else begin
                        baudCnt <= baudCnt + 16'd1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    TxSerial <= 1'b1;
                    baudCnt  <= 16'd0;
                    bitIdx   <= 3'd0;
                end
            endcase
        end
    end

endmodule
